// File: rtl/uart_rx_frame_controller_if.sv
// Bundles the receive-side byte stream and the display-side handshake of the UART RX frame
// controller.
//
// Signals:
//   Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR - byte and flags from the receive validation stage
//   disp_ready                              - display driver has latched disp_word
//   disp_word, disp_load                    - assembled frame and its frame-available request
//   frame_err, err_count, busy              - error pulse, saturating error count, non-idle flag
//
// Modports:
//   master - drives the byte stream and disp_ready (the receiver/display environment)
//   slave  - the frame controller itself
interface uart_rx_frame_controller_if;
    logic [7:0]  Rx_DATA;
    logic        Rx_VALID;
    logic        Rx_FERROR;
    logic        Rx_PERROR;
    logic        disp_ready;
    logic [15:0] disp_word;
    logic        disp_load;
    logic        frame_err;
    logic [3:0]  err_count;
    logic        busy;

    modport master (
        output Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, disp_ready,
        input  disp_word, disp_load, frame_err, err_count, busy
    );

    modport slave (
        input  Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR, disp_ready,
        output disp_word, disp_load, frame_err, err_count, busy
    );
endinterface

// File: rtl/uart_rx_frame_controller.sv
// Assembles pairs of received UART bytes (high byte first) into a 16-bit word for a 4-digit
// 7-segment display, with a timeout between the two bytes, overrun detection while a frame is
// waiting for the display, and a saturating error counter.
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - asynchronous, active-high reset
//   bus   - slave side of uart_rx_frame_controller_if (byte stream in, display handshake out)
//
// Parameters:
//   TIMEOUT_CYCLES - max clk cycles allowed in WAIT_LO between the high and low byte
module uart_rx_frame_controller #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input logic                         clk,
    input logic                         reset,
    uart_rx_frame_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitLo,
        StPresent,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic        valid_q;
    logic [7:0]  high_q, high_d;
    logic [15:0] word_q, word_d;
    logic [15:0] tmo_q, tmo_d;
    logic [3:0]  err_q, err_d;
    logic        err_inc;
    logic        byte_event;
    logic        bad_byte;
    logic        disp_load;
    logic        frame_err;

    // Rising edge of Rx_VALID: one event per high period regardless of its length.
    assign byte_event = bus.Rx_VALID & ~valid_q;
    assign bad_byte   = bus.Rx_FERROR | bus.Rx_PERROR;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            high_q  <= 8'h00;
            word_q  <= 16'h0000;
            tmo_q   <= 16'h0000;
            err_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            valid_q <= bus.Rx_VALID;
            high_q  <= high_d;
            word_q  <= word_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        high_d    = high_q;
        word_d    = word_q;
        tmo_d     = tmo_q;
        err_inc   = 1'b0;
        disp_load = 1'b0;
        frame_err = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (byte_event) begin
                    if (bad_byte) begin
                        state_d = StErr;
                    end else begin
                        high_d  = bus.Rx_DATA;
                        tmo_d   = 16'h0000;
                        state_d = StWaitLo;
                    end
                end
            end
            StWaitLo: begin
                // A byte arriving in the timeout cycle wins over the timeout.
                if (byte_event) begin
                    if (bad_byte) begin
                        state_d = StErr;
                    end else begin
                        word_d  = {high_q, bus.Rx_DATA};
                        state_d = StPresent;
                    end
                end else if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            StPresent: begin
                disp_load = 1'b1;
                if (bus.disp_ready) begin
                    if (byte_event && bad_byte) begin
                        state_d = StErr;
                    end else if (byte_event) begin
                        // Display takes the frame while the next high byte arrives.
                        high_d  = bus.Rx_DATA;
                        tmo_d   = 16'h0000;
                        state_d = StWaitLo;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (byte_event) begin
                    // Overrun: the pending frame is kept, the new byte is dropped.
                    frame_err = 1'b1;
                    err_inc   = 1'b1;
                end
            end
            StErr: begin
                // Byte events here are deliberately ignored.
                frame_err = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StErr && state_q != StErr) begin
            err_inc = 1'b1;
        end

        err_d = (err_inc && err_q != 4'hF) ? err_q + 4'h1 : err_q;
    end

    assign bus.disp_word = word_q;
    assign bus.disp_load = disp_load;
    assign bus.frame_err = frame_err;
    assign bus.err_count = err_q;
    assign bus.busy      = (state_q != StIdle);

endmodule
